mxfp8_decode_sched: RTL and testbench

MXFP8_DECODE_SCHED -- requirements
Module: mxfp8_decode_sched

---
 rtl/mxfp8_decode_sched.sv | 174 +++++++++++++++++
 tb/tb_mxfp8_decode_sched.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mxfp8_decode_sched.sv
// Shared FP8 E4M3 decoder with round-robin A/B arbitration and MX block tracking.
// Define MXFP8_BLOCK_LOCK_EN to keep the grant on one source for a whole MX block.
module mxfp8_decode_sched #(
   parameter int BLOCK_LEN = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       a_valid,
   input  logic [7:0] a_data,
   output logic       a_ready,
   input  logic       b_valid,
   input  logic [7:0] b_data,
   output logic       b_ready,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_src,
   output logic       out_sign,
   output logic [3:0] out_exp,
   output logic [3:0] out_mant,
   output logic       out_last
);

   localparam int CW = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(BLOCK_LEN - 1);

   logic [CW-1:0] cnt_a_q, cnt_a_d;
   logic [CW-1:0] cnt_b_q, cnt_b_d;
   logic          last_b_q, last_b_d;

   logic          out_valid_q, out_valid_d;
   logic          out_src_q, out_src_d;
   logic          out_sign_q, out_sign_d;
   logic [3:0]    out_exp_q, out_exp_d;
   logic [3:0]    out_mant_q, out_mant_d;
   logic          out_last_q, out_last_d;

   logic          can_load;
   logic          rr_a, rr_b;
   logic          gnt_a, gnt_b;
   logic          hs_a, hs_b;
   logic          a_last, b_last;
   logic [7:0]    sel_data;

   assign can_load = !out_valid_q || out_ready;
   assign a_last   = (cnt_a_q == CNT_LAST);
   assign b_last   = (cnt_b_q == CNT_LAST);

   // On a tie the source that did not win last time goes next.
   assign rr_a = a_valid && (!b_valid || last_b_q);
   assign rr_b = b_valid && (!a_valid || !last_b_q);

`ifdef MXFP8_BLOCK_LOCK_EN
   typedef enum logic [1:0] {
      IDLE,
      OWN_A,
      OWN_B
   } lock_e;

   lock_e lock_q, lock_d;

   always_comb begin
      gnt_a  = 1'b0;
      gnt_b  = 1'b0;
      lock_d = lock_q;
      unique case (lock_q)
         IDLE: begin
            gnt_a = rr_a;
            gnt_b = rr_b;
            if (hs_a) begin
               lock_d = a_last ? IDLE : OWN_A;
            end else if (hs_b) begin
               lock_d = b_last ? IDLE : OWN_B;
            end
         end
         OWN_A: begin
            gnt_a = a_valid;
            if (hs_a && a_last) begin
               lock_d = IDLE;
            end
         end
         OWN_B: begin
            gnt_b = b_valid;
            if (hs_b && b_last) begin
               lock_d = IDLE;
            end
         end
         default: lock_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lock_q <= IDLE;
      end else begin
         lock_q <= lock_d;
      end
   end
`else
   assign gnt_a = rr_a;
   assign gnt_b = rr_b;
`endif

   assign a_ready = rst_n && can_load && gnt_a;
   assign b_ready = rst_n && can_load && gnt_b;
   assign hs_a    = a_valid && a_ready;
   assign hs_b    = b_valid && b_ready;

   assign sel_data = hs_b ? b_data : a_data;

   always_comb begin
      cnt_a_d  = cnt_a_q;
      cnt_b_d  = cnt_b_q;
      last_b_d = last_b_q;
      if (hs_a) begin
         cnt_a_d  = a_last ? '0 : cnt_a_q + CW'(1);
         last_b_d = 1'b0;
      end
      if (hs_b) begin
         cnt_b_d  = b_last ? '0 : cnt_b_q + CW'(1);
         last_b_d = 1'b1;
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_src_d   = out_src_q;
      out_sign_d  = out_sign_q;
      out_exp_d   = out_exp_q;
      out_mant_d  = out_mant_q;
      out_last_d  = out_last_q;
      if (hs_a || hs_b) begin
         out_valid_d = 1'b1;
         out_src_d   = hs_b;
         out_sign_d  = sel_data[7];
         out_exp_d   = sel_data[6:3];
         out_mant_d  = {(sel_data[6:3] != 4'h0), sel_data[2:0]};
         out_last_d  = hs_b ? b_last : a_last;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_a_q     <= '0;
         cnt_b_q     <= '0;
         last_b_q    <= 1'b1;
         out_valid_q <= 1'b0;
         out_src_q   <= 1'b0;
         out_sign_q  <= 1'b0;
         out_exp_q   <= 4'h0;
         out_mant_q  <= 4'h0;
         out_last_q  <= 1'b0;
      end else begin
         cnt_a_q     <= cnt_a_d;
         cnt_b_q     <= cnt_b_d;
         last_b_q    <= last_b_d;
         out_valid_q <= out_valid_d;
         out_src_q   <= out_src_d;
         out_sign_q  <= out_sign_d;
         out_exp_q   <= out_exp_d;
         out_mant_q  <= out_mant_d;
         out_last_q  <= out_last_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_src   = out_src_q;
   assign out_sign  = out_sign_q;
   assign out_exp   = out_exp_q;
   assign out_mant  = out_mant_q;
   assign out_last  = out_last_q;

endmodule

// File: tb/tb_mxfp8_decode_sched.sv
// Scoreboard bench for mxfp8_decode_sched: driver pushes expected outputs,
// monitor pops and compares on every output handshake.
module tb_mxfp8_decode_sched;

   localparam int BL = 32;

   typedef struct packed {
      logic [7:0] d;
      logic       s;
      logic [3:0] e;
      logic [3:0] m;
   } item_t;

   typedef struct packed {
      logic       src;
      logic       s;
      logic [3:0] e;
      logic [3:0] m;
      logic       last;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       a_valid = 1'b0;
   logic [7:0] a_data = 8'h00;
   logic       b_valid = 1'b0;
   logic [7:0] b_data = 8'h00;
   logic       out_ready = 1'b0;
   logic       a_ready, b_ready, out_valid;
   logic       out_src, out_sign, out_last;
   logic [3:0] out_exp, out_mant;

   always #5 clk = ~clk;

   mxfp8_decode_sched #(.BLOCK_LEN(BL)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .a_valid  (a_valid),
      .a_data   (a_data),
      .a_ready  (a_ready),
      .b_valid  (b_valid),
      .b_data   (b_data),
      .b_ready  (b_ready),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_src  (out_src),
      .out_sign (out_sign),
      .out_exp  (out_exp),
      .out_mant (out_mant),
      .out_last (out_last)
   );

   int    n_tests = 0;
   int    n_fail = 0;
   item_t qa[$];
   item_t qb[$];
   exp_t  sb[$];
   logic  src_log[$];
   logic  last_log[$];

   int    m_cnt_a = 0;
   int    m_cnt_b = 0;
   bit    m_last_b = 1'b1;
   bit    m_ov = 1'b0;
   int    m_own = 0;

   task automatic check(string name, int act, int req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic item_t mk(logic [7:0] d);
      item_t t;
      t.d = d;
      t.s = d[7];
      t.e = d[6:3];
      t.m = {(d[6:3] != 4'h0), d[2:0]};
      return t;
   endfunction

   function automatic item_t hv(logic [7:0] d, logic s, logic [3:0] e, logic [3:0] m);
      item_t t;
      t.d = d;
      t.s = s;
      t.e = e;
      t.m = m;
      return t;
   endfunction

   task automatic drive_inputs();
      a_valid = (qa.size() > 0);
      a_data  = a_valid ? qa[0].d : 8'h00;
      b_valid = (qb.size() > 0);
      b_data  = b_valid ? qb[0].d : 8'h00;
   endtask

   task automatic cycle();
      bit can, ga, gb, ra, rb;
      @(negedge clk);
      can = !m_ov || out_ready;
      ga  = a_valid && (m_own == 1 || (m_own == 0 && (!b_valid || m_last_b)));
      gb  = b_valid && (m_own == 2 || (m_own == 0 && (!a_valid || !m_last_b)));
      ra  = rst_n && can && ga;
      rb  = rst_n && can && gb;
      check("a_ready", int'(a_ready), int'(ra));
      check("b_ready", int'(b_ready), int'(rb));
      if (!rst_n) begin
         m_cnt_a  = 0;
         m_cnt_b  = 0;
         m_last_b = 1'b1;
         m_own    = 0;
         m_ov     = 1'b0;
         sb.delete();
      end else begin
         check("out_valid", int'(out_valid), int'(m_ov));
         if (ra) begin
            sb.push_back('{1'b0, qa[0].s, qa[0].e, qa[0].m, (m_cnt_a == BL - 1)});
`ifdef MXFP8_BLOCK_LOCK_EN
            m_own = (m_cnt_a == BL - 1) ? 0 : 1;
`endif
            m_cnt_a  = (m_cnt_a == BL - 1) ? 0 : m_cnt_a + 1;
            m_last_b = 1'b0;
            void'(qa.pop_front());
         end
         if (rb) begin
            sb.push_back('{1'b1, qb[0].s, qb[0].e, qb[0].m, (m_cnt_b == BL - 1)});
`ifdef MXFP8_BLOCK_LOCK_EN
            m_own = (m_cnt_b == BL - 1) ? 0 : 2;
`endif
            m_cnt_b  = (m_cnt_b == BL - 1) ? 0 : m_cnt_b + 1;
            m_last_b = 1'b1;
            void'(qb.pop_front());
         end
         m_ov = (ra || rb) ? 1'b1 : (out_ready ? 1'b0 : m_ov);
      end
      @(posedge clk);
      #1;
      drive_inputs();
   endtask

   task automatic run(int mode);
      int k;
      k = 0;
      while ((qa.size() > 0 || qb.size() > 0 || sb.size() > 0) && k < 2000) begin
         out_ready = (mode == 0) ? 1'b1 : (k % 3 != 1);
         cycle();
         k++;
      end
      if (k >= 2000) check("run_timeout", k, 0);
      out_ready = 1'b1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      qa.delete();
      qb.delete();
      drive_inputs();
      out_ready = 1'b1;
      cycle();
      cycle();
      check("rst_valid", int'(out_valid), 0);
      check("rst_src", int'(out_src), 0);
      check("rst_sign", int'(out_sign), 0);
      check("rst_exp", int'(out_exp), 0);
      check("rst_mant", int'(out_mant), 0);
      check("rst_last", int'(out_last), 0);
      rst_n = 1'b1;
      src_log.delete();
      last_log.delete();
   endtask

   initial begin
      exp_t e, act, prev;
      bit   stall;
      stall = 1'b0;
      prev  = '0;
      forever begin
         @(negedge clk);
         act = '{out_src, out_sign, out_exp, out_mant, out_last};
         if (!rst_n) begin
            stall = 1'b0;
         end else begin
            if (stall) check("hold", int'(act), int'(prev));
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  check("unexpected_out", int'(act), -1);
               end else begin
                  e = sb.pop_front();
                  check("out", int'(act), int'(e));
                  src_log.push_back(out_src);
                  last_log.push_back(out_last);
               end
            end
            stall = out_valid && !out_ready;
            prev  = act;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      item_t vec[6];
      vec[0] = hv(8'h38, 1'b0, 4'h7, 4'h8);
      vec[1] = hv(8'h85, 1'b1, 4'h0, 4'h5);
      vec[2] = hv(8'h7E, 1'b0, 4'hF, 4'hE);
      vec[3] = hv(8'h00, 1'b0, 4'h0, 4'h0);
      vec[4] = hv(8'hFF, 1'b1, 4'hF, 4'hF);
      vec[5] = hv(8'h08, 1'b0, 4'h1, 4'h8);

      do_reset();

      // single element latency and decode
      qa.push_back(vec[0]);
      drive_inputs();
      run(0);
      check("first_src_cnt", src_log.size(), 1);

      // directed decode vectors through both sources
      do_reset();
      foreach (vec[i]) qa.push_back(vec[i]);
      foreach (vec[i]) qb.push_back(vec[i]);
      drive_inputs();
      run(0);
      check("dir_cnt", src_log.size(), 12);

      // both sources streaming continuously
      do_reset();
      for (int i = 0; i < 2 * BL; i++) qa.push_back(mk(8'(i * 7 + 3)));
      for (int i = 0; i < 2 * BL; i++) qb.push_back(mk(8'(i * 11 + 129)));
      drive_inputs();
      run(0);
      check("rr_cnt", src_log.size(), 4 * BL);
      for (int i = 0; i < 4 * BL && i < src_log.size(); i++) begin
`ifdef MXFP8_BLOCK_LOCK_EN
         check("rr_src", int'(src_log[i]), (i / BL) % 2);
         check("rr_last", int'(last_log[i]), int'((i % BL) == BL - 1));
`else
         check("rr_src", int'(src_log[i]), i % 2);
         check("rr_last", int'(last_log[i]), int'(((i / 2) % BL) == BL - 1));
`endif
      end

      // output stall for 5 cycles, then resume with no bubble
      do_reset();
      for (int i = 0; i < 8; i++) qa.push_back(mk(8'(i * 29 + 17)));
      drive_inputs();
      out_ready = 1'b1;
      cycle();
      cycle();
      cycle();
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) cycle();
      run(0);
      check("stall_cnt", src_log.size(), 8);

      // 33 A elements: last only on the 32nd
      do_reset();
      for (int i = 0; i < BL + 1; i++) qa.push_back(mk(8'(i)));
      drive_inputs();
      run(0);
      check("blk_cnt", last_log.size(), BL + 1);
      for (int i = 0; i < BL + 1 && i < last_log.size(); i++)
         check("blk_last", int'(last_log[i]), int'(i == BL - 1));

      // reset mid-block discards output and partial count
      do_reset();
      for (int i = 0; i < 20; i++) qa.push_back(mk(8'(i + 64)));
      drive_inputs();
      out_ready = 1'b1;
      for (int i = 0; i < 11; i++) cycle();
      do_reset();
      for (int i = 0; i < BL; i++) qa.push_back(mk(8'(i * 3)));
      drive_inputs();
      run(0);
      check("mid_cnt", last_log.size(), BL);
      for (int i = 0; i < BL && i < last_log.size(); i++)
         check("mid_last", int'(last_log[i]), int'(i == BL - 1));

      // mixed traffic with intermittent backpressure
      do_reset();
      for (int i = 0; i < 40; i++) qa.push_back(mk(8'(i * 37 + 5)));
      for (int i = 0; i < 40; i++) qb.push_back(mk(8'(i * 53 + 90)));
      drive_inputs();
      run(1);
      check("mix_cnt", src_log.size(), 80);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
